// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// opcodes, ALUOp / ALUControl / ImmSrc / ResultSrc / ALU source select codes.
// No ports. Imported by the interface, the ALU decoder and the controller top.
package riscv_ctrl_pkg;

  // FSM state encodings (4-bit)
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  // Opcodes Instr[6:0]
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_RTYP = 7'b0110011;
  localparam logic [6:0] OP_ITYP = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Internal ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALUControl
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA / ALUSrcB
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  // Immediate format from opcode; unknown opcodes fall back to I-type.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_LW, OP_ITYP: imm_src_of = IMM_I;
      OP_SW:          imm_src_of = IMM_S;
      OP_BEQ:         imm_src_of = IMM_B;
      OP_JAL:         imm_src_of = IMM_J;
      default:        imm_src_of = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/riscv_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// Ports: none; signals op/funct3/funct7b5/Zero/MemReady toward the controller,
// mux selects, write enables, ALUControl, ImmSrc, Halted back to the datapath.
// With RISCV_CTRL_PERF_EN defined, also carries CycleCount and InstrCount.
interface riscv_multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [2:0] ALUControl;
  logic [1:0] ImmSrc;
  logic       Halted;
`ifdef RISCV_CTRL_PERF_EN
  logic [31:0] CycleCount;
  logic [31:0] InstrCount;
`endif

  // master: the controller
  modport master (
    input  op, funct3, funct7b5, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ALUControl, ImmSrc, Halted
`ifdef RISCV_CTRL_PERF_EN
    , output CycleCount, InstrCount
`endif
  );

  // slave: the datapath
  modport slave (
    output op, funct3, funct7b5, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ALUControl, ImmSrc, Halted
`ifdef RISCV_CTRL_PERF_EN
    , input CycleCount, InstrCount
`endif
  );
endinterface

// File: rtl/riscv_alu_decoder.sv
// ALU operation decode from ALUOp, funct3, funct7b5 and op[5].
// Latency: combinational. Backpressure: none.
// Ports: alu_op_i[1:0], funct3_i[2:0], funct7b5_i, op5_i -> alu_control_o[2:0].
module riscv_alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       op5_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) can subtract; addi ignores Instr[30].
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control_o = ALU_SLT;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Moore control FSM for a shared-memory multicycle RV32I-subset datapath.
// Latency at MemReady=1: beq 3, sw/R/I/jal 4, lw 5 cycles; each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds 1.
// Backpressure: MemReady low stalls FETCH/MEMREAD/MEMWRITE (MemWrite held); ignored elsewhere.
// Ports: clk, reset (sync, active-high), bus (riscv_multicycle_ctrl_if.master).
// Parameter HALT_ON_ILLEGAL: 1 -> unknown opcode enters sticky HALT, 0 -> treated as NOP.
// Optional feature macro RISCV_CTRL_PERF_EN: adds CycleCount / InstrCount counters.
module riscv_multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  riscv_multicycle_ctrl_if.master       bus
);

  logic [3:0] state_q, state_d;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, halted;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] alu_ctrl;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYP:      state_d = S_EXECR;
          OP_ITYP:      state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        endcase
      end
      // op[5] distinguishes sw (0100011) from lw (0000011)
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode; reset forces every enable and select to zero.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    halted     = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = bus.MemReady;
        pc_write   = bus.MemReady;
      end
      S_DECODE: begin
        // Branch target OldPC + imm computed speculatively into ALUOut
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD:  adr_src = 1'b1;
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB:    reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a = SRCA_RS1;
        alu_op    = ALUOP_SUB;
        pc_write  = bus.Zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_HALT:     halted = 1'b1;
      default: ;
    endcase
  end

  riscv_alu_decoder u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (bus.funct3),
    .funct7b5_i    (bus.funct7b5),
    .op5_i         (bus.op[5]),
    .alu_control_o (alu_ctrl)
  );

  assign bus.PCWrite    = reset ? 1'b0 : pc_write;
  assign bus.AdrSrc     = reset ? 1'b0 : adr_src;
  assign bus.MemWrite   = reset ? 1'b0 : mem_write;
  assign bus.IRWrite    = reset ? 1'b0 : ir_write;
  assign bus.RegWrite   = reset ? 1'b0 : reg_write;
  assign bus.ResultSrc  = reset ? 2'b00 : result_src;
  assign bus.ALUSrcA    = reset ? 2'b00 : alu_src_a;
  assign bus.ALUSrcB    = reset ? 2'b00 : alu_src_b;
  assign bus.ALUControl = reset ? 3'b000 : alu_ctrl;
  assign bus.ImmSrc     = reset ? 2'b00 : imm_src_of(bus.op);
  assign bus.Halted     = halted;

`ifdef RISCV_CTRL_PERF_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      if (state_q != S_HALT)
        cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q == S_FETCH && bus.MemReady)
        instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign bus.CycleCount = cycle_cnt_q;
  assign bus.InstrCount = instr_cnt_q;
`endif

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
module tb_riscv_multicycle_ctrl;
  import riscv_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  riscv_multicycle_ctrl_if bus ();

  riscv_multicycle_ctrl #(.HALT_ON_ILLEGAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = OP_RTYP;
    bus.funct3    = 3'b000;
    bus.funct7b5  = 1'b0;
    bus.Zero      = 1'b0;
    bus.MemReady  = 1'b1;

    // Power-on reset, two edges
    tick();
    tick();
    chk("rst_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
    chk("rst_irwrite", {31'd0, bus.IRWrite}, 32'd0);
    chk("rst_srcb",    {30'd0, bus.ALUSrcB}, 32'd0);
    chk("rst_result",  {30'd0, bus.ResultSrc}, 32'd0);
    reset = 1'b0;
    #1;
    chk("fetch_irwrite", {31'd0, bus.IRWrite}, 32'd1);
    chk("fetch_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
    chk("fetch_srcb",    {30'd0, bus.ALUSrcB}, 32'd2);
    chk("fetch_result",  {30'd0, bus.ResultSrc}, 32'd2);
    chk("fetch_adrsrc",  {31'd0, bus.AdrSrc}, 32'd0);

    // FETCH stall
    bus.MemReady = 1'b0;
    #1;
    chk("stall_irwrite", {31'd0, bus.IRWrite}, 32'd0);
    chk("stall_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
    tick();
    chk("stall_hold_srcb", {30'd0, bus.ALUSrcB}, 32'd2);

    // lw: F D MA MR MWB
    bus.MemReady = 1'b1;
    bus.op       = OP_LW;
    #1;
    chk("lw_f_irwrite", {31'd0, bus.IRWrite}, 32'd1);
    chk("lw_f_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    chk("lw_d_srca",  {30'd0, bus.ALUSrcA}, 32'd1);
    chk("lw_d_srcb",  {30'd0, bus.ALUSrcB}, 32'd1);
    chk("lw_d_imm",   {30'd0, bus.ImmSrc}, 32'd0);
    chk("lw_d_irwrite", {31'd0, bus.IRWrite}, 32'd0);
    chk("lw_d_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    chk("lw_ma_srca", {30'd0, bus.ALUSrcA}, 32'd2);
    chk("lw_ma_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    chk("lw_mr_adrsrc", {31'd0, bus.AdrSrc}, 32'd1);
    chk("lw_mr_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    chk("lw_wb_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("lw_wb_result",   {30'd0, bus.ResultSrc}, 32'd1);
    tick();
    chk("lw_back_fetch", {31'd0, bus.IRWrite}, 32'd1);
    chk("lw_back_regwrite", {31'd0, bus.RegWrite}, 32'd0);

    // sw with 3 MemReady=0 cycles in MEMWRITE
    bus.op = OP_SW;
    tick();
    chk("sw_d_imm", {30'd0, bus.ImmSrc}, 32'd1);
    tick();
    chk("sw_ma_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    bus.MemReady = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sw_mw_memwrite%0d", i), {31'd0, bus.MemWrite}, 32'd1);
      chk($sformatf("sw_mw_adrsrc%0d", i),   {31'd0, bus.AdrSrc}, 32'd1);
      tick();
    end
    bus.MemReady = 1'b1;
    #1;
    chk("sw_mw_memwrite3", {31'd0, bus.MemWrite}, 32'd1);
    tick();
    chk("sw_back_memwrite", {31'd0, bus.MemWrite}, 32'd0);
    chk("sw_back_fetch",    {31'd0, bus.IRWrite}, 32'd1);

    // beq taken
    bus.op   = OP_BEQ;
    bus.Zero = 1'b1;
    tick();
    chk("beq_d_imm",     {30'd0, bus.ImmSrc}, 32'd2);
    chk("beq_d_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
    tick();
    chk("beq_t_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
    chk("beq_t_aluctl",  {29'd0, bus.ALUControl}, 32'd1);
    tick();
    chk("beq_t_fetch", {31'd0, bus.IRWrite}, 32'd1);
    // beq not taken
    bus.Zero = 1'b0;
    tick();
    tick();
    chk("beq_nt_pcwrite", {31'd0, bus.PCWrite}, 32'd0);
    chk("beq_nt_aluctl",  {29'd0, bus.ALUControl}, 32'd1);
    tick();
    chk("beq_nt_fetch", {31'd0, bus.IRWrite}, 32'd1);

    // R-type sub
    bus.op       = OP_RTYP;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b1;
    tick();
    tick();
    chk("r_sub_aluctl", {29'd0, bus.ALUControl}, 32'd1);
    chk("r_sub_srca",   {30'd0, bus.ALUSrcA}, 32'd2);
    chk("r_sub_srcb",   {30'd0, bus.ALUSrcB}, 32'd0);
    tick();
    chk("r_wb_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    chk("r_wb_result",   {30'd0, bus.ResultSrc}, 32'd0);
    tick();
    chk("r_back_fetch", {31'd0, bus.IRWrite}, 32'd1);

    // R-type slt
    bus.funct3 = 3'b010;
    tick();
    tick();
    chk("r_slt_aluctl", {29'd0, bus.ALUControl}, 32'd5);
    tick();
    tick();

    // I-type addi with Instr[30]=1 stays add
    bus.op     = OP_ITYP;
    bus.funct3 = 3'b000;
    tick();
    chk("i_d_imm", {30'd0, bus.ImmSrc}, 32'd0);
    tick();
    chk("i_add_aluctl", {29'd0, bus.ALUControl}, 32'd0);
    chk("i_add_srcb",   {30'd0, bus.ALUSrcB}, 32'd1);
    tick();
    chk("i_wb_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    tick();
    // I-type ori
    bus.funct3 = 3'b110;
    tick();
    tick();
    chk("i_or_aluctl", {29'd0, bus.ALUControl}, 32'd3);
    tick();
    tick();

    // jal: F D JAL ALUWB
    bus.op = OP_JAL;
    tick();
    chk("jal_d_imm", {30'd0, bus.ImmSrc}, 32'd3);
    tick();
    chk("jal_pcwrite",  {31'd0, bus.PCWrite}, 32'd1);
    chk("jal_srca",     {30'd0, bus.ALUSrcA}, 32'd1);
    chk("jal_srcb",     {30'd0, bus.ALUSrcB}, 32'd2);
    chk("jal_regwrite", {31'd0, bus.RegWrite}, 32'd0);
    tick();
    chk("jal_wb_regwrite", {31'd0, bus.RegWrite}, 32'd1);
    tick();
    chk("jal_back_fetch", {31'd0, bus.IRWrite}, 32'd1);

    // Reset mid-EXECR
    bus.op       = OP_RTYP;
    bus.funct3   = 3'b000;
    bus.funct7b5 = 1'b1;
    tick();
    tick();
    chk("pre_rst_aluctl", {29'd0, bus.ALUControl}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_aluctl", {29'd0, bus.ALUControl}, 32'd0);
    chk("mid_rst_srca",   {30'd0, bus.ALUSrcA}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    bus.op = 7'b1111111;
    #1;
    chk("post_rst_irwrite", {31'd0, bus.IRWrite}, 32'd1);
    chk("post_rst_pcwrite", {31'd0, bus.PCWrite}, 32'd1);
`ifdef RISCV_CTRL_PERF_EN
    chk("perf_cyc0",   bus.CycleCount, 32'd0);
    chk("perf_instr0", bus.InstrCount, 32'd0);
`endif

    // Illegal opcode -> sticky HALT
    tick();
    chk("ill_d_srca",   {30'd0, bus.ALUSrcA}, 32'd1);
    chk("ill_d_halted", {31'd0, bus.Halted}, 32'd0);
`ifdef RISCV_CTRL_PERF_EN
    chk("perf_cyc1",   bus.CycleCount, 32'd1);
    chk("perf_instr1", bus.InstrCount, 32'd1);
`endif
    tick();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("halt_halted%0d", i), {31'd0, bus.Halted}, 32'd1);
      chk($sformatf("halt_en%0d", i),
          {28'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}, 32'd0);
`ifdef RISCV_CTRL_PERF_EN
      chk($sformatf("halt_cyc%0d", i),   bus.CycleCount, 32'd2);
      chk($sformatf("halt_instr%0d", i), bus.InstrCount, 32'd1);
`endif
      tick();
    end

    // Reset leaves HALT
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("unhalt_halted",  {31'd0, bus.Halted}, 32'd0);
    chk("unhalt_irwrite", {31'd0, bus.IRWrite}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
